// File: rtl/sad_accumulator.sv
// Accumulates |a - b| over blocks of LEN accepted pairs and emits each block's SAD.
// sad/out_valid register on the LEN-th accept; in_ready drops while a result is held.
module sad_accumulator #(
  parameter int WIDTH  = 5,
  parameter int LEN    = 4,
  parameter int SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH+$clog2(LEN)-1:0] sad,
  output logic [$clog2(LEN):0]       count
);

  localparam int SW = WIDTH + $clog2(LEN);
  localparam int CW = $clog2(LEN) + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state;
  logic [SW-1:0]   acc;
  logic [WIDTH:0]  ax;
  logic [WIDTH:0]  bx;
  logic [WIDTH:0]  diff;
  logic [WIDTH-1:0] d;
  logic            last_pair;

  // One extra bit holds any difference of two WIDTH-bit operands in either
  // interpretation; its magnitude always fits back into WIDTH bits.
  always_comb begin
    ax = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
    bx = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
    diff = ax - bx;
    d = WIDTH'(diff[WIDTH] ? (~diff + (WIDTH+1)'(1)) : diff);
  end

  assign last_pair = (count == CW'(LEN - 1));
  assign in_ready  = (state == ACCUM) && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      sad       <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (last_pair) begin
              sad       <= acc + SW'(d);
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= HOLD;
            end else begin
              acc   <= acc + SW'(d);
              count <= count + CW'(1);
            end
          end
        end
        HOLD: begin
          // No bypass: the accept cycle still reports in_ready = 0.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_accumulator.sv
// Scoreboard bench: unsigned and signed instances share stimulus; a reference
// model computes expected SADs from accepted pairs and a monitor checks outputs.
module tb_sad_accumulator;

  localparam int WIDTH = 5;
  localparam int LEN   = 4;
  localparam int SW    = WIDTH + $clog2(LEN);
  localparam int CW    = $clog2(LEN) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_ready = 1'b0;

  logic             u_in_ready, s_in_ready;
  logic             u_out_valid, s_out_valid;
  logic [SW-1:0]    u_sad, s_sad;
  logic [CW-1:0]    u_count, s_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int  qu[$];
  int  qs[$];
  int  ba[$];
  int  bb[$];
  bit  holding = 0;

  always #5 clk = ~clk;

  sad_accumulator #(.WIDTH(WIDTH), .LEN(LEN), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .out_valid(u_out_valid), .out_ready(out_ready), .sad(u_sad), .count(u_count)
  );

  sad_accumulator #(.WIDTH(WIDTH), .LEN(LEN), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready), .sad(s_sad), .count(s_count)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int absdiff(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic int as_signed(input int x);
    return (x >= (1 << (WIDTH - 1))) ? x - (1 << WIDTH) : x;
  endfunction

  // Drive one cycle of inputs, then advance the reference model past the edge.
  task automatic step(input bit v, input int av, input int bv, input bit fl,
                      input bit ordy, input bit rs);
    int su, ss;
    in_valid = v; a = WIDTH'(av); b = WIDTH'(bv);
    flush = fl; out_ready = ordy; rst = rs;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      if (holding) begin
        if (qu.size() > 0) void'(qu.pop_back());
        if (qs.size() > 0) void'(qs.pop_back());
      end
      ba.delete(); bb.delete();
      holding = 0;
    end else if (holding) begin
      if (ordy) holding = 0;
    end else if (v) begin
      ba.push_back(av % (1 << WIDTH));
      bb.push_back(bv % (1 << WIDTH));
      if (ba.size() == LEN) begin
        su = 0; ss = 0;
        foreach (ba[k]) begin
          su += absdiff(ba[k], bb[k]);
          ss += absdiff(as_signed(ba[k]), as_signed(bb[k]));
        end
        qu.push_back(su);
        qs.push_back(ss);
        ba.delete(); bb.delete();
        holding = 1;
      end
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, ordy, 0);
  endtask

  task automatic send(input int av, input int bv, input bit ordy);
    bit done;
    int tries;
    done = 0; tries = 0;
    while (!done) begin
      done = !holding;
      step(1, av, bv, 0, ordy, 0);
      tries++;
      if (!done && tries > 20) begin
        chk("send_timeout", 1, 0);
        done = 1;
      end
    end
  endtask

  // Monitor: handshake/state checks every cycle, result checks while valid.
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = !holding && !flush && !rst;
    chk("u_in_ready", u_in_ready, exp_rdy);
    chk("s_in_ready", s_in_ready, exp_rdy);
    chk("u_out_valid", u_out_valid, holding);
    chk("s_out_valid", s_out_valid, holding);
    chk("u_count", u_count, ba.size());
    chk("s_count", s_count, ba.size());
    if (u_out_valid) begin
      if (qu.size() == 0) chk("u_unexpected_result", 1, 0);
      else chk("u_sad", u_sad, qu[0]);
    end
    if (s_out_valid) begin
      if (qs.size() == 0) chk("s_unexpected_result", 1, 0);
      else chk("s_sad", s_sad, qs[0]);
    end
    if (out_ready && !flush && !rst) begin
      if (u_out_valid && qu.size() > 0) void'(qu.pop_front());
      if (s_out_valid && qs.size() > 0) void'(qs.pop_front());
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("reset_u_sad", u_sad, 0);
    chk("reset_s_sad", s_sad, 0);
    idle(1, 0);

    // Basic unsigned block: 4+4+31+0 = 39
    send(6, 2, 1); send(2, 6, 1); send(0, 31, 1); send(9, 9, 1);
    idle(2, 1);

    // Largest-difference block, no overflow
    for (int i = 0; i < LEN; i++) send(0, 31, 1);
    idle(2, 1);

    // Exhaustive operand sweep
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        send(i, j, 1);
    idle(2, 1);

    // Signed extremes: -16/15, 15/-16, -1/1, 3/-3 -> signed SAD 70
    send(16, 15, 1); send(15, 16, 1); send(31, 1, 1); send(3, 29, 1);
    idle(2, 1);

    // Backpressure: held result, ignored input pulses, then release
    send(10, 3, 0); send(1, 20, 0); send(31, 31, 0); send(4, 17, 0);
    for (int i = 0; i < 5; i++) step(i % 2, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < LEN; i++) send($urandom_range(0, 31), $urandom_range(0, 31), 1);
    idle(2, 1);

    // Bubbles then flush (pair presented with flush is not accepted)
    step(1, 5, 0, 0, 1, 0);
    idle(2, 1);
    step(1, 0, 3, 0, 1, 0);
    idle(1, 1);
    step(1, 9, 9, 1, 1, 0);
    idle(1, 1);
    for (int i = 0; i < LEN; i++) send(1, 0, 1);
    idle(2, 1);

    // Flush while a result is held drops it
    for (int i = 0; i < LEN; i++) send(12, 2, 0);
    idle(1, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(2, 1);

    // Reset mid-block, then a fresh block of (7,2) -> 20
    send(3, 0, 1); send(0, 8, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("midrst_u_sad", u_sad, 0);
    chk("midrst_s_sad", s_sad, 0);
    for (int i = 0; i < LEN; i++) send(7, 2, 1);
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
           ($urandom % 50) == 0, ($urandom % 3) != 0, ($urandom % 300) == 0);

    idle(4, 1);
    chk("u_queue_drained", qu.size(), 0);
    chk("s_queue_drained", qs.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
